// File: rtl/led_share_arbiter.sv
// rtl/led_share_arbiter.sv - round-robin LED owner arbiter with minimum dwell; optional PWM dimming via LED_PWM_EN
module led_share_arbiter #(
    parameter int         NREQ     = 4,
    parameter int         DWELL    = 25000000,
    parameter logic [3:0] IDLE_PAT = 4'b0000,
    parameter int         PWM_BITS = 4
) (
    input  logic                  w_clk,
    input  logic                  w_rst_n,
    input  logic [NREQ-1:0]       w_req,
    input  logic [4*NREQ-1:0]     w_pat,
    input  logic [PWM_BITS-1:0]   w_duty,
    output logic [NREQ-1:0]       w_gnt,
    output logic                  w_busy,
    output logic [3:0]            w_led
);

    localparam int               IDX_W    = $clog2(NREQ);
    localparam logic [31:0]      CNT_MAX  = 32'(DWELL - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] r_last;
    logic [31:0]      cnt;
    logic [3:0]       r_pat;
    logic [NREQ-1:0]  others;
    logic [IDX_W-1:0] pick_idle;
    logic [IDX_W-1:0] pick_rot;
    logic [3:0]       own_pat;

    // First set request bit scanning last+1, last+2, ... modulo NREQ.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [IDX_W-1:0] last);
        logic [IDX_W-1:0] pick;
        logic             found;
        int               idx;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(last) + k) % NREQ;
            if (!found && req[idx]) begin
                pick  = IDX_W'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [IDX_W-1:0] i);
        return NREQ'(1) << i;
    endfunction

    // Candidate winners and the current owner's pattern; r_last is the owner while in OWN.
    always_comb begin
        others    = w_req & ~onehot(r_last);
        pick_idle = rr_pick(w_req, r_last);
        pick_rot  = rr_pick(others, r_last);
        own_pat   = w_pat[4*r_last +: 4];
    end

    // Ownership FSM: grant, dwell counting, early release, rotation and hold.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            state  <= IDLE;
            w_gnt  <= '0;
            r_last <= LAST_RST;
            cnt    <= '0;
            r_pat  <= IDLE_PAT;
        end else begin
            case (state)
                IDLE: begin
                    r_pat <= IDLE_PAT;
                    if (|w_req) begin
                        state  <= OWN;
                        w_gnt  <= onehot(pick_idle);
                        r_last <= pick_idle;
                        cnt    <= '0;
                    end
                end
                OWN: begin
                    if (!w_req[r_last]) begin
                        // Owner drop beats dwell expiry; one idle cycle before re-arbitration.
                        state <= IDLE;
                        w_gnt <= '0;
                        r_pat <= IDLE_PAT;
                        cnt   <= '0;
                    end else begin
                        r_pat <= own_pat;
                        if (cnt == CNT_MAX && |others) begin
                            w_gnt  <= onehot(pick_rot);
                            r_last <= pick_rot;
                            cnt    <= '0;
                        end else if (cnt != CNT_MAX) begin
                            cnt <= cnt + 32'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign w_busy = (state == OWN);

`ifdef LED_PWM_EN
    logic [PWM_BITS-1:0] p;

    // Free-running PWM phase and registered brightness gate on the pattern.
    always_ff @(posedge w_clk) begin
        if (!w_rst_n) begin
            p     <= '0;
            w_led <= IDLE_PAT;
        end else begin
            p     <= p + PWM_BITS'(1);
            w_led <= (p < w_duty) ? r_pat : 4'b0000;
        end
    end
`else
    logic unused_duty;
    assign unused_duty = ^w_duty;
    assign w_led       = r_pat;
`endif

endmodule

// File: tb/tb_led_share_arbiter.sv
// tb/tb_led_share_arbiter.sv - directed self-checking bench for led_share_arbiter
module tb_led_share_arbiter;

    localparam int NREQ     = 4;
    localparam int DWELL    = 4;
    localparam int PWM_BITS = 2;

    logic                 clk;
    logic                 rst_n;
    logic [NREQ-1:0]      req;
    logic [4*NREQ-1:0]    pat;
    logic [PWM_BITS-1:0]  duty;
    logic [NREQ-1:0]      gnt;
    logic                 busy;
    logic [3:0]           led;

    int n_assert = 0;
    int n_fail   = 0;

    led_share_arbiter #(
        .NREQ     (NREQ),
        .DWELL    (DWELL),
        .IDLE_PAT (4'b0000),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .w_clk   (clk),
        .w_rst_n (rst_n),
        .w_req   (req),
        .w_pat   (pat),
        .w_duty  (duty),
        .w_gnt   (gnt),
        .w_busy  (busy),
        .w_led   (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_led(input string tag, input logic [3:0] exp);
`ifndef LED_PWM_EN
        chk(tag, 32'(led), 32'(exp));
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        rst_n = 1'b1;
    endtask

    logic [3:0] samp [8];
    int         n_on;

    initial begin
        rst_n = 1'b0;
        req   = '0;
        pat   = '0;
        duty  = '0;

        // Reset with all requests pending
        req = 4'b1111;
        pat = 16'h4321;
        do_reset(3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_led", 32'(led), 32'h0);
        tick();
        chk("first_gnt", 32'(gnt), 32'b0001);
        chk("first_busy", 32'(busy), 32'h1);
        chk_led("first_led_idle", 4'h0);
        tick();
        chk_led("first_led_pat", 4'h1);

        // Rotation between requesters 0 and 2, no idle cycle
        do_reset(1);
        req = 4'b0101;
        pat = 16'h050A;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("rot_gnt_%0d", k), 32'(gnt),
                ((k / 4) % 2 == 0) ? 32'b0001 : 32'b0100);
            chk($sformatf("rot_busy_%0d", k), 32'(busy), 32'h1);
            chk_led($sformatf("rot_led_%0d", k),
                    (k == 0) ? 4'h0 : ((((k - 1) / 4) % 2 == 0) ? 4'hA : 4'h5));
        end

        // Early release by owner 1 at count 1, requester 3 waiting
        do_reset(1);
        req = 4'b0010;
        pat = 16'hC070;
        tick();
        chk("er_gnt1", 32'(gnt), 32'b0010);
        tick();
        chk_led("er_led1", 4'h7);
        req = 4'b1000;
        tick();
        chk("er_gnt_drop", 32'(gnt), 32'h0);
        chk("er_busy_drop", 32'(busy), 32'h0);
        chk_led("er_led_drop", 4'h0);
        tick();
        chk("er_gnt3", 32'(gnt), 32'b1000);
        tick();
        chk_led("er_led3", 4'hC);

        // Hold with a lone requester, then late competitor
        do_reset(1);
        req = 4'b0100;
        pat = 16'h0900;
        tick();
        for (int k = 0; k < 20; k++) begin
            tick();
            chk($sformatf("hold_gnt_%0d", k), 32'(gnt), 32'b0100);
        end
        chk_led("hold_led", 4'h9);
        req = 4'b0101;
        tick();
        chk("hold_rot_gnt", 32'(gnt), 32'b0001);

        // Owner drop coinciding with dwell expiry goes to idle
        do_reset(1);
        req = 4'b0011;
        for (int k = 0; k < 4; k++) tick();
        chk("sim_gnt_own", 32'(gnt), 32'b0001);
        req = 4'b0010;
        tick();
        chk("sim_gnt_drop", 32'(gnt), 32'h0);
        tick();
        chk("sim_gnt_next", 32'(gnt), 32'b0010);

        // Mid-ownership reset with owner 3 at count 2
        do_reset(1);
        req = 4'b1000;
        for (int k = 0; k < 3; k++) tick();
        chk("mr3_gnt", 32'(gnt), 32'b1000);
        req   = 4'b1001;
        rst_n = 1'b0;
        tick();
        chk("mr3_gnt_rst", 32'(gnt), 32'h0);
        chk("mr3_busy_rst", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mr3_gnt_after", 32'(gnt), 32'b0001);

        // Mid-ownership reset with owner 1: r_last must return to NREQ-1
        do_reset(1);
        req = 4'b0010;
        for (int k = 0; k < 2; k++) tick();
        chk("mr1_gnt", 32'(gnt), 32'b0010);
        req   = 4'b0110;
        rst_n = 1'b0;
        tick();
        chk("mr1_gnt_rst", 32'(gnt), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("mr1_gnt_after", 32'(gnt), 32'b0010);

`ifdef LED_PWM_EN
        // PWM: duty 2 of 4 gives F,F,0,0; duty 0 keeps LEDs dark
        do_reset(1);
        req  = 4'b0001;
        pat  = 16'h000F;
        duty = 2'd2;
        for (int k = 0; k < 6; k++) tick();
        n_on = 0;
        for (int k = 0; k < 8; k++) begin
            samp[k] = led;
            if (led == 4'hF) n_on++;
            tick();
        end
        chk("pwm_on_count", 32'(n_on), 32'd4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("pwm_period_%0d", k), 32'(samp[k]), 32'(samp[k+4]));
        chk("pwm_pair", 32'(((samp[0] == samp[1]) || (samp[1] == samp[2])) ? 1 : 0), 32'd1);
        duty = 2'd0;
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("pwm_off_%0d", k), 32'(led), 32'h0);
            tick();
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/led_share_arbiter.md
Name: led_share_arbiter

Overview:
- Round-robin arbiter and dwell scheduler sharing the board's 4 user LEDs (Arty A7-35T) among NREQ requesters, e.g. heartbeat counter, UART status and debug probes.
- A granted requester owns the LEDs for at least DWELL cycles; ownership then rotates to the next pending requester.
- Sits between the requester logic and the top-level w_led output.

Parameters:
- NREQ, 4, number of requesters (2..8).
- DWELL, 25000000, minimum ownership time in w_clk cycles (>=1); 0.25 s at 100 MHz.
- IDLE_PAT, 4'b0000, LED pattern driven when no requester owns the LEDs.
- PWM_BITS, 4, width of the brightness duty value (used only with the optional feature).

Ports:
- w_clk  in  1  system clock (100 MHz board clock).
- w_rst_n  in  1  synchronous active-low reset, sampled on posedge w_clk.
- w_req  in  NREQ  per-requester request; level, held while the requester wants the LEDs.
- w_pat  in  4*NREQ  LED pattern of requester i on bits [4i+3:4i].
- w_duty  in  PWM_BITS  global brightness duty; ignored unless LED_PWM_EN is defined.
- w_gnt  out  NREQ  one-hot grant, registered.
- w_busy  out  1  high while any requester owns the LEDs (state OWN).
- w_led  out  4  LED drive, registered.

Behaviour:
- Reset (w_rst_n==0 at posedge):
  - state=IDLE, w_gnt=0, w_busy=0, w_led=IDLE_PAT.
  - dwell counter=0; r_last=NREQ-1, so requester 0 has first priority.
  - Reset asserted mid-ownership drops the grant on that same edge.
- States: IDLE, OWN.
- IDLE:
  - If w_req==0: stay in IDLE, w_led=IDLE_PAT.
  - Otherwise select the first set w_req bit scanning r_last+1, r_last+2, ... modulo NREQ.
  - On that edge: w_gnt becomes one-hot for the winner, r_last=winner, counter=0, state=OWN.
  - Grant latency is 1 cycle from the req sample.
- OWN, owner o:
  - w_led <= w_pat[o] every cycle; w_led lags w_pat by 1 cycle.
  - Counter increments by 1 per cycle and saturates at DWELL-1 (32-bit, no wrap).
- Early release: if w_req[o]==0 is sampled, the next edge gives state=IDLE, w_gnt=0, w_led=IDLE_PAT. This holds regardless of the counter. A new arbitration starts from IDLE on the following cycle, so there is 1 idle cycle.
- Rotation: if counter==DWELL-1, w_req[o]==1 and any other w_req bit is set:
  - Hand over directly on the same edge, with no idle cycle.
  - New owner is chosen by the round-robin scan from o+1; w_gnt switches one-hot to it, r_last=new owner, counter=0.
  - The new owner's pattern appears on w_led 1 cycle after that edge.
- Hold: if counter==DWELL-1 and no other request is pending, the owner keeps the LEDs and the counter stays saturated. A request arriving later rotates on the next edge.
- Simultaneous owner drop and dwell expiry: the drop wins; go to IDLE.
- A requester whose request drops and re-asserts while it is not the owner has no memory; only level requests count.
- DWELL=1: rotation can occur on every cycle after the grant edge.
- Invariants: w_gnt is always one-hot or zero; w_busy==|w_gnt.

Optional Feature:
- Macro: LED_PWM_EN.
- Defined:
  - A free-running PWM_BITS counter p increments every cycle; reset value 0.
  - w_led = (p < w_duty) ? registered pattern : 4'b0000, where the gate is registered (1 extra cycle of latency on w_led).
  - w_duty=0 gives LEDs always off; all-ones gives on for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
  - Applies to IDLE_PAT as well.
- Undefined: no PWM counter; w_duty is unconnected internally; w_led is the registered pattern at full on.

Test Plan (DWELL=4, NREQ=4):
- Reset: w_rst_n=0 for 3 cycles with w_req=4'b1111 -> w_gnt=0, w_busy=0, w_led=0000. Release reset -> w_gnt=0001 one cycle later; w_led=w_pat[3:0] on the next cycle.
- Rotation: w_req=4'b0101 held, pat0=4'hA, pat2=4'h5 -> w_gnt sequence 0001 x4 cycles, 0100 x4, 0001 ..., with no idle cycle; w_led alternates A/5 delayed 1 cycle.
- Early release: owner 1, drop w_req[1] at count 1 -> next edge w_gnt=0, w_led=0000, w_busy=0. w_req[3] pending -> w_gnt=1000 the following edge.
- Hold: only w_req[2] set for 20 cycles -> w_gnt=0100 throughout, counter saturates at 3. Raise w_req[0] -> w_gnt=0001 on the next edge.
- Mid-op reset: during OWN of requester 3 at count 2, pulse w_rst_n=0 for 1 cycle -> grant cleared that edge; afterwards requester 0 wins first (r_last reset).
- LED_PWM_EN: PWM_BITS=2, w_duty=2, pat=4'hF -> w_led pattern F,F,0,0 repeating; w_duty=0 -> w_led=0 constantly.
